cci_mpf_shim_mdata_tag: RTL

Request/response tag shim that owns the Mdata field on the QLP side of the MPF shim stack. It saves each AFU read/write request's Mdata in a table, sends the request toward the QLP with a locally allocated tag in Mdata, and restores the original Mdata on the matching response. Responses may arrive in any order. Upstream shims can then reserve Mdata bits freely, because AFU Mdata values are opaque and returned intact.

---
 rtl/cci_mpf_shim_mdata_tag_if.sv | 48 ++++
 rtl/cci_mpf_shim_mdata_tag.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_shim_mdata_tag_if.sv
// CCI-style request/response bundle shared by the MPF shim stack.
// to_qlp is a shim's port toward the platform; to_afu is its port toward the user side.
interface cci_mpf_if #(
    parameter int CCI_DATA_WIDTH   = 512,
    parameter int CCI_RX_HDR_WIDTH = 18,
    parameter int CCI_TX_HDR_WIDTH = 61
);
    logic                        resetb;

    logic [CCI_TX_HDR_WIDTH-1:0] C0TxHdr;
    logic                        C0TxRdValid;
    logic                        C0TxAlmFull;

    logic [CCI_TX_HDR_WIDTH-1:0] C1TxHdr;
    logic [CCI_DATA_WIDTH-1:0]   C1TxData;
    logic                        C1TxWrValid;
    logic                        C1TxIrValid;
    logic                        C1TxAlmFull;

    logic [CCI_RX_HDR_WIDTH-1:0] C0RxHdr;
    logic [CCI_DATA_WIDTH-1:0]   C0RxData;
    logic                        C0RxWrValid;
    logic                        C0RxRdValid;
    logic                        C0RxCgValid;
    logic                        C0RxUgValid;
    logic                        C0RxIrValid;

    logic [CCI_RX_HDR_WIDTH-1:0] C1RxHdr;
    logic                        C1RxWrValid;
    logic                        C1RxIrValid;

    modport to_qlp (
        output C0TxHdr, C0TxRdValid,
        output C1TxHdr, C1TxData, C1TxWrValid, C1TxIrValid,
        input  C0TxAlmFull, C1TxAlmFull,
        input  C0RxHdr, C0RxData, C0RxWrValid, C0RxRdValid, C0RxCgValid, C0RxUgValid, C0RxIrValid,
        input  C1RxHdr, C1RxWrValid, C1RxIrValid
    );

    modport to_afu (
        output resetb,
        input  C0TxHdr, C0TxRdValid,
        input  C1TxHdr, C1TxData, C1TxWrValid, C1TxIrValid,
        output C0TxAlmFull, C1TxAlmFull,
        output C0RxHdr, C0RxData, C0RxWrValid, C0RxRdValid, C0RxCgValid, C0RxUgValid, C0RxIrValid,
        output C1RxHdr, C1RxWrValid, C1RxIrValid
    );
endinterface

// File: rtl/cci_mpf_shim_mdata_tag.sv
// Mdata tag shim: replaces AFU Mdata with locally allocated tags and restores it on responses.
// Optional runtime tag checks are enabled by defining CCI_MPF_MDATA_TAG_CHECK_EN.
module cci_mpf_shim_mdata_tag #(
    parameter int CCI_DATA_WIDTH   = 512,
    parameter int CCI_RX_HDR_WIDTH = 18,
    parameter int CCI_TX_HDR_WIDTH = 61,
    parameter int CCI_TAG_WIDTH    = 13,
    parameter int N_READ_TAGS      = 64,
    parameter int N_WRITE_TAGS     = 64,
    parameter int ALM_FULL_SLACK   = 4
) (
    input  logic      clk,
    input  logic      resetb,
    cci_mpf_if.to_qlp qlp,
    cci_mpf_if.to_afu afu
);
    localparam int RD_IDX_W = $clog2(N_READ_TAGS);
    localparam int WR_IDX_W = $clog2(N_WRITE_TAGS);

    typedef logic [RD_IDX_W-1:0] rd_idx_t;
    typedef logic [WR_IDX_W-1:0] wr_idx_t;
    typedef logic [RD_IDX_W:0]   rd_cnt_t;
    typedef logic [WR_IDX_W:0]   wr_cnt_t;

    logic [N_READ_TAGS-1:0]   rd_busy_q, rd_busy_d;
    logic [N_WRITE_TAGS-1:0]  wr_busy_q, wr_busy_d;
    logic [CCI_TAG_WIDTH-1:0] rd_table_q [N_READ_TAGS];
    logic [CCI_TAG_WIDTH-1:0] wr_table_q [N_WRITE_TAGS];

    rd_idx_t rd_alloc_idx, rd_rsp_idx;
    wr_idx_t wr_alloc_idx, wr_rsp0_idx, wr_rsp1_idx;
    rd_cnt_t rd_free_d;
    wr_cnt_t wr_free_d;
    logic    rd_req, wr_req, rd_rsp, wr_rsp0, wr_rsp1;
    logic    rd_alm_d, wr_alm_d, rd_alm_q, wr_alm_q;

    logic [CCI_TX_HDR_WIDTH-1:0] c0_tx_hdr_d, c0_tx_hdr_q, c1_tx_hdr_d, c1_tx_hdr_q;
    logic [CCI_RX_HDR_WIDTH-1:0] c0_rx_hdr_d, c0_rx_hdr_q, c1_rx_hdr_d, c1_rx_hdr_q;
    logic [CCI_DATA_WIDTH-1:0]   c1_tx_data_q, c0_rx_data_q;
    logic c0_tx_rd_q, c1_tx_wr_q, c1_tx_ir_q;
    logic c0_rx_wr_q, c0_rx_rd_q, c0_rx_cg_q, c0_rx_ug_q, c0_rx_ir_q, c1_rx_wr_q, c1_rx_ir_q;

    assign rd_req      = afu.C0TxRdValid;
    assign wr_req      = afu.C1TxWrValid;
    assign rd_rsp      = qlp.C0RxRdValid;
    assign wr_rsp0     = qlp.C0RxWrValid;
    assign wr_rsp1     = qlp.C1RxWrValid;
    assign rd_rsp_idx  = qlp.C0RxHdr[RD_IDX_W-1:0];
    assign wr_rsp0_idx = qlp.C0RxHdr[WR_IDX_W-1:0];
    assign wr_rsp1_idx = qlp.C1RxHdr[WR_IDX_W-1:0];

    // Lowest free index wins; allocation sees only busy state from the previous edge.
    always_comb begin
        rd_alloc_idx = '0;
        for (int i = N_READ_TAGS - 1; i >= 0; i--)
            if (!rd_busy_q[i]) rd_alloc_idx = rd_idx_t'(i);
    end

    always_comb begin
        wr_alloc_idx = '0;
        for (int i = N_WRITE_TAGS - 1; i >= 0; i--)
            if (!wr_busy_q[i]) wr_alloc_idx = wr_idx_t'(i);
    end

    always_comb begin
        rd_busy_d = rd_busy_q;
        if (rd_rsp) rd_busy_d[rd_rsp_idx] = 1'b0;
        if (rd_req) rd_busy_d[rd_alloc_idx] = 1'b1;

        wr_busy_d = wr_busy_q;
        if (wr_rsp0) wr_busy_d[wr_rsp0_idx] = 1'b0;
        if (wr_rsp1) wr_busy_d[wr_rsp1_idx] = 1'b0;
        if (wr_req)  wr_busy_d[wr_alloc_idx] = 1'b1;
    end

    // Almost-full is computed from post-edge occupancy so the registered flag matches the pool.
    always_comb begin
        rd_free_d = rd_cnt_t'(N_READ_TAGS);
        for (int i = 0; i < N_READ_TAGS; i++)
            rd_free_d = rd_free_d - rd_cnt_t'(rd_busy_d[i]);
        wr_free_d = wr_cnt_t'(N_WRITE_TAGS);
        for (int i = 0; i < N_WRITE_TAGS; i++)
            wr_free_d = wr_free_d - wr_cnt_t'(wr_busy_d[i]);
        rd_alm_d = qlp.C0TxAlmFull || (int'(rd_free_d) < ALM_FULL_SLACK);
        wr_alm_d = qlp.C1TxAlmFull || (int'(wr_free_d) < ALM_FULL_SLACK);
    end

    always_comb begin
        c0_tx_hdr_d = afu.C0TxHdr;
        if (rd_req) c0_tx_hdr_d[CCI_TAG_WIDTH-1:0] = CCI_TAG_WIDTH'(rd_alloc_idx);

        c1_tx_hdr_d = afu.C1TxHdr;
        if (wr_req) c1_tx_hdr_d[CCI_TAG_WIDTH-1:0] = CCI_TAG_WIDTH'(wr_alloc_idx);

        c0_rx_hdr_d = qlp.C0RxHdr;
        if (rd_rsp)       c0_rx_hdr_d[CCI_TAG_WIDTH-1:0] = rd_table_q[rd_rsp_idx];
        else if (wr_rsp0) c0_rx_hdr_d[CCI_TAG_WIDTH-1:0] = wr_table_q[wr_rsp0_idx];

        c1_rx_hdr_d = qlp.C1RxHdr;
        if (wr_rsp1) c1_rx_hdr_d[CCI_TAG_WIDTH-1:0] = wr_table_q[wr_rsp1_idx];
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rd_busy_q   <= '0;
            wr_busy_q   <= '0;
            rd_alm_q    <= 1'b1;
            wr_alm_q    <= 1'b1;
            c0_tx_rd_q  <= 1'b0;
            c1_tx_wr_q  <= 1'b0;
            c1_tx_ir_q  <= 1'b0;
            c0_rx_wr_q  <= 1'b0;
            c0_rx_rd_q  <= 1'b0;
            c0_rx_cg_q  <= 1'b0;
            c0_rx_ug_q  <= 1'b0;
            c0_rx_ir_q  <= 1'b0;
            c1_rx_wr_q  <= 1'b0;
            c1_rx_ir_q  <= 1'b0;
        end else begin
            rd_busy_q   <= rd_busy_d;
            wr_busy_q   <= wr_busy_d;
            rd_alm_q    <= rd_alm_d;
            wr_alm_q    <= wr_alm_d;
            c0_tx_rd_q  <= rd_req;
            c1_tx_wr_q  <= wr_req;
            c1_tx_ir_q  <= afu.C1TxIrValid;
            c0_rx_wr_q  <= wr_rsp0;
            c0_rx_rd_q  <= rd_rsp;
            c0_rx_cg_q  <= qlp.C0RxCgValid;
            c0_rx_ug_q  <= qlp.C0RxUgValid;
            c0_rx_ir_q  <= qlp.C0RxIrValid;
            c1_rx_wr_q  <= wr_rsp1;
            c1_rx_ir_q  <= qlp.C1RxIrValid;
        end
    end

    // Headers, data and tag tables carry no reset; valids qualify them.
    always_ff @(posedge clk) begin
        c0_tx_hdr_q  <= c0_tx_hdr_d;
        c1_tx_hdr_q  <= c1_tx_hdr_d;
        c1_tx_data_q <= afu.C1TxData;
        c0_rx_hdr_q  <= c0_rx_hdr_d;
        c1_rx_hdr_q  <= c1_rx_hdr_d;
        c0_rx_data_q <= qlp.C0RxData;
        if (rd_req) rd_table_q[rd_alloc_idx] <= afu.C0TxHdr[CCI_TAG_WIDTH-1:0];
        if (wr_req) wr_table_q[wr_alloc_idx] <= afu.C1TxHdr[CCI_TAG_WIDTH-1:0];
    end

`ifdef CCI_MPF_MDATA_TAG_CHECK_EN
    always_ff @(posedge clk) begin
        if (resetb) begin
            if (rd_rsp && (32'(qlp.C0RxHdr[CCI_TAG_WIDTH-1:0]) >= N_READ_TAGS))
                $fatal(1, "mdata_tag: read response tag %0d out of range", qlp.C0RxHdr[CCI_TAG_WIDTH-1:0]);
            if (wr_rsp0 && (32'(qlp.C0RxHdr[CCI_TAG_WIDTH-1:0]) >= N_WRITE_TAGS))
                $fatal(1, "mdata_tag: C0 write response tag %0d out of range", qlp.C0RxHdr[CCI_TAG_WIDTH-1:0]);
            if (wr_rsp1 && (32'(qlp.C1RxHdr[CCI_TAG_WIDTH-1:0]) >= N_WRITE_TAGS))
                $fatal(1, "mdata_tag: C1 write response tag %0d out of range", qlp.C1RxHdr[CCI_TAG_WIDTH-1:0]);
            if (rd_rsp && !rd_busy_q[rd_rsp_idx])
                $fatal(1, "mdata_tag: read response to free tag %0d", rd_rsp_idx);
            if (wr_rsp0 && !wr_busy_q[wr_rsp0_idx])
                $fatal(1, "mdata_tag: C0 write response to free tag %0d", wr_rsp0_idx);
            if (wr_rsp1 && !wr_busy_q[wr_rsp1_idx])
                $fatal(1, "mdata_tag: C1 write response to free tag %0d", wr_rsp1_idx);
            if (rd_req && (&rd_busy_q))
                $fatal(1, "mdata_tag: read request with no free tag");
            if (wr_req && (&wr_busy_q))
                $fatal(1, "mdata_tag: write request with no free tag");
        end
    end
`endif

    assign qlp.C0TxHdr     = c0_tx_hdr_q;
    assign qlp.C0TxRdValid = c0_tx_rd_q;
    assign qlp.C1TxHdr     = c1_tx_hdr_q;
    assign qlp.C1TxData    = c1_tx_data_q;
    assign qlp.C1TxWrValid = c1_tx_wr_q;
    assign qlp.C1TxIrValid = c1_tx_ir_q;

    assign afu.resetb      = resetb;
    assign afu.C0TxAlmFull = rd_alm_q;
    assign afu.C1TxAlmFull = wr_alm_q;
    assign afu.C0RxHdr     = c0_rx_hdr_q;
    assign afu.C0RxData    = c0_rx_data_q;
    assign afu.C0RxWrValid = c0_rx_wr_q;
    assign afu.C0RxRdValid = c0_rx_rd_q;
    assign afu.C0RxCgValid = c0_rx_cg_q;
    assign afu.C0RxUgValid = c0_rx_ug_q;
    assign afu.C0RxIrValid = c0_rx_ir_q;
    assign afu.C1RxHdr     = c1_rx_hdr_q;
    assign afu.C1RxWrValid = c1_rx_wr_q;
    assign afu.C1RxIrValid = c1_rx_ir_q;
endmodule
